// File: rtl/i2c_pkg.sv
// i2c_pkg: command codes, FSM states and quarter-index width for the I2C byte controller
package i2c_pkg;
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;
  localparam int QTR_W = 2;
  typedef enum logic [2:0] {IDLE, START, STOP, BIT, DONE_ST} state_e;
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: CLK_DIV-cycle quarter timer held at zero while the target stretches SCL
module i2c_quarter_tick #(
  parameter int CLK_DIV = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic restart,
  output logic end_of_quarter
);
  logic [15:0] cnt_q, cnt_d;
  assign end_of_quarter = !hold && cnt_q == 16'(CLK_DIV - 1);
  always_comb cnt_d = (restart || hold || end_of_quarter) ? '0 : cnt_q + 16'd1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/i2c_byte_controller.sv
// i2c_byte_controller: byte-level I2C initiator issuing START/STOP/WRITE/READ over open-drain pulldowns
module i2c_byte_controller import i2c_pkg::*; #(
  parameter int CLK_DIV = 30
) (
  input  logic       ICE_CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD,
  input  logic [7:0] TX_DATA,
  input  logic       CMD_NACK,
  output logic       DONE,
  output logic [7:0] RX_DATA,
  output logic       ACK_RX,
  output logic       BUSY,
  input  logic       SDA_DIN,
  input  logic       SCL_DIN,
  output logic       SDA_PULLDOWN,
  output logic       SCL_PULLDOWN
);
  state_e state_q, state_d;
  logic [QTR_W-1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d, rx_q, rx_d;
  logic rd_q, rd_d, nack_q, nack_d, ack_q, ack_d;
  logic sda_pd_q, sda_pd_d, scl_pd_q, scl_pd_d;
  logic [1:0] sda_sync_q, scl_sync_q;
  logic sda_s, scl_s, accept, hold, eoq;
  assign sda_s = sda_sync_q[1];
  assign scl_s = scl_sync_q[1];
  assign CMD_READY = state_q == IDLE || state_q == DONE_ST;
  assign BUSY = !CMD_READY;
  assign DONE = state_q == DONE_ST;
  assign accept = CMD_VALID && CMD_READY;
  assign hold = !scl_s && ((state_q == BIT && qtr_q == 2'd2) || ((state_q == START || state_q == STOP) && qtr_q == 2'd1));
  assign SDA_PULLDOWN = sda_pd_q;
  assign SCL_PULLDOWN = scl_pd_q;
  assign RX_DATA = rx_q;
  assign ACK_RX = ack_q;
  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(ICE_CLK),
    .rst(RST),
    .hold(hold),
    .restart(accept),
    .end_of_quarter(eoq)
  );
  always_comb begin
    state_d = state_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    sh_d = sh_q;
    rx_d = rx_q;
    rd_d = rd_q;
    nack_d = nack_q;
    ack_d = ack_q;
    sda_pd_d = sda_pd_q;
    scl_pd_d = scl_pd_q;
    if (accept) begin
      state_d = CMD == CMD_START ? START : CMD == CMD_STOP ? STOP : BIT;
      qtr_d = '0;
      bit_d = '0;
      sh_d = TX_DATA;
      rd_d = CMD == CMD_READ;
      nack_d = CMD_NACK;
      sda_pd_d = CMD == CMD_STOP || (CMD == CMD_WRITE && !TX_DATA[7]);
      scl_pd_d = CMD == CMD_START ? scl_pd_q : 1'b1;
    end else if (state_q == DONE_ST) begin
      state_d = IDLE;
    end else if (eoq && state_q != IDLE) begin
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        START: begin
          scl_pd_d = qtr_q == 2'd0 ? 1'b0 : qtr_q == 2'd2 ? 1'b1 : scl_pd_q;
          sda_pd_d = qtr_q == 2'd1 ? 1'b1 : sda_pd_q;
        end
        STOP: begin
          scl_pd_d = qtr_q == 2'd0 ? 1'b0 : scl_pd_q;
          sda_pd_d = qtr_q == 2'd2 ? 1'b0 : sda_pd_q;
        end
        default: begin
          scl_pd_d = qtr_q == 2'd1 ? 1'b0 : qtr_q == 2'd3 ? 1'b1 : scl_pd_q;
          sda_pd_d = (qtr_q != 2'd3 || bit_q == 4'd8) ? sda_pd_q : bit_q == 4'd7 ? rd_q && !nack_q : !rd_q && !sh_q[7];
          sh_d = (qtr_q == 2'd2 && bit_q != 4'd8) ? {sh_q[6:0], sda_s} : sh_q;
          ack_d = (qtr_q == 2'd2 && bit_q == 4'd8 && !rd_q) ? !sda_s : ack_q;
          rx_d = (qtr_q == 2'd3 && bit_q == 4'd8 && rd_q) ? sh_q : rx_q;
          bit_d = qtr_q == 2'd3 ? bit_q + 4'd1 : bit_q;
        end
      endcase
      if (qtr_q == 2'd3 && (state_q != BIT || bit_q == 4'd8)) state_d = DONE_ST;
    end
  end
  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      qtr_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      rx_q <= '0;
      rd_q <= 1'b0;
      nack_q <= 1'b0;
      ack_q <= 1'b0;
      sda_pd_q <= 1'b0;
      scl_pd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      rx_q <= rx_d;
      rd_q <= rd_d;
      nack_q <= nack_d;
      ack_q <= ack_d;
      sda_pd_q <= sda_pd_d;
      scl_pd_q <= scl_pd_d;
    end
  end
  always_ff @(posedge ICE_CLK) begin
    sda_sync_q <= {sda_sync_q[0], SDA_DIN};
    scl_sync_q <= {scl_sync_q[0], SCL_DIN};
  end
endmodule

// File: tb/tb_i2c_byte_controller.sv
// tb_i2c_byte_controller: directed tests of the I2C byte controller against an open-drain bus and target model
module tb_i2c_byte_controller;
  import i2c_pkg::*;
  localparam int D = 4;
  localparam int STRETCH = 50;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_nack = 0;
  logic [1:0] cmd = 0;
  logic [7:0] tx_data = 0;
  logic cmd_ready, done, busy, ack_rx, sda_pd, scl_pd, sda_line, scl_line;
  logic [7:0] rx_data;
  int tests = 0, fails = 0;
  int falls = 0, rises = 0, base = 0, dones = 0, glitches = 0, str_cnt = 0;
  logic [15:0] rise_sh = 0;
  logic ack_en = 0, rd_en = 0, str_en = 0, in_byte = 0;
  logic [7:0] tgt_byte = 0;
  logic sda_prev = 1, scl_prev = 1;
  int rel;
  logic tgt_sda_low, tgt_scl_low;
  assign rel = falls - base;
  assign tgt_sda_low = (ack_en && rel == 8) || (rd_en && rel >= 0 && rel < 8 && !tgt_byte[3'(7 - rel)]);
  assign tgt_scl_low = str_en && rel == 3 && str_cnt <= STRETCH;
  assign sda_line = !(sda_pd || tgt_sda_low);
  assign scl_line = !(scl_pd || tgt_scl_low);
  i2c_byte_controller #(.CLK_DIV(D)) dut (
    .ICE_CLK(clk),
    .RST(rst),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD(cmd),
    .TX_DATA(tx_data),
    .CMD_NACK(cmd_nack),
    .DONE(done),
    .RX_DATA(rx_data),
    .ACK_RX(ack_rx),
    .BUSY(busy),
    .SDA_DIN(sda_line),
    .SCL_DIN(scl_line),
    .SDA_PULLDOWN(sda_pd),
    .SCL_PULLDOWN(scl_pd)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (str_en && tgt_scl_low && !scl_pd) str_cnt++;
    if (scl_prev && !scl_line) falls++;
    if (!scl_prev && scl_line) begin
      rises++;
      rise_sh = {rise_sh[14:0], sda_line};
    end
    if (in_byte && scl_prev && scl_line && sda_prev !== sda_line) glitches++;
    if (done) dones++;
    scl_prev = scl_line;
    sda_prev = sda_line;
  end
  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic n);
    int w = 0;
    while (!cmd_ready && w < 1000) begin
      @(posedge clk);
      #1;
      w++;
    end
    cmd = c;
    tx_data = d;
    cmd_nack = n;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd = ~c;
    tx_data = ~d;
    cmd_nack = ~n;
    base = falls;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: DONE=%b after %0d cycles, required 1", done, n);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) begin
      cmd_valid = 1'($urandom);
      cmd = 2'($urandom);
      tx_data = 8'($urandom);
      cmd_nack = 1'($urandom);
      @(posedge clk);
      #1;
    end
    tests += 7;
    if (sda_pd !== 1'b0) begin fails++; $display("FAIL reset_sda_pd: got %b, required 0", sda_pd); end
    if (scl_pd !== 1'b0) begin fails++; $display("FAIL reset_scl_pd: got %b, required 0", scl_pd); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, required 0", done); end
    if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    if (ack_rx !== 1'b0) begin fails++; $display("FAIL reset_ack_rx: got %b, required 0", ack_rx); end
    cmd_valid = 0;
    rst = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic test_write_ack;
    int n, d0, r0;
    ack_en = 1;
    d0 = dones;
    issue(CMD_START, 8'h00, 1'b0);
    wait_done(n);
    tests++;
    if (n !== 4 * D) begin fails++; $display("FAIL start_cycles: got %0d, required %0d", n, 4 * D); end
    r0 = rises;
    in_byte = 1;
    issue(CMD_WRITE, 8'hA5, 1'b0);
    wait_done(n);
    in_byte = 0;
    @(negedge clk);
    #1;
    tests += 6;
    if (rise_sh[8:1] !== 8'hA5) begin fails++; $display("FAIL write_a5_bits: got %h, required a5", rise_sh[8:1]); end
    if (rises - r0 !== 9) begin fails++; $display("FAIL write_a5_rises: got %0d, required 9", rises - r0); end
    if (ack_rx !== 1'b1) begin fails++; $display("FAIL write_a5_ack: got %b, required 1", ack_rx); end
    if (dones - d0 !== 2) begin fails++; $display("FAIL write_a5_done_pulses: got %0d, required 2", dones - d0); end
    if (n !== 36 * D + 18) begin fails++; $display("FAIL write_a5_cycles: got %0d, required %0d", n, 36 * D + 18); end
    if (scl_pd !== 1'b1) begin fails++; $display("FAIL write_a5_scl_handback: got %b, required 1", scl_pd); end
    ack_en = 0;
  endtask
  task automatic test_no_responder;
    int n;
    in_byte = 1;
    issue(CMD_WRITE, 8'h3C, 1'b0);
    wait_done(n);
    in_byte = 0;
    tests += 3;
    if (ack_rx !== 1'b0) begin fails++; $display("FAIL noresp_ack: got %b, required 0", ack_rx); end
    if (n !== 36 * D + 18) begin fails++; $display("FAIL noresp_cycles: got %0d, required %0d", n, 36 * D + 18); end
    if (rise_sh[8:0] !== 9'h079) begin fails++; $display("FAIL noresp_bits: got %h, required 079", rise_sh[8:0]); end
  endtask
  task automatic test_read;
    int n;
    rd_en = 1;
    tgt_byte = 8'h96;
    in_byte = 1;
    issue(CMD_READ, 8'h00, 1'b1);
    wait_done(n);
    tests += 3;
    if (rx_data !== 8'h96) begin fails++; $display("FAIL read_nack_data: got %h, required 96", rx_data); end
    if (rise_sh[0] !== 1'b1) begin fails++; $display("FAIL read_nack_bit9: got %b, required 1", rise_sh[0]); end
    if (n !== 36 * D + 18) begin fails++; $display("FAIL read_nack_cycles: got %0d, required %0d", n, 36 * D + 18); end
    tgt_byte = 8'h5B;
    issue(CMD_READ, 8'h00, 1'b0);
    wait_done(n);
    in_byte = 0;
    tests += 3;
    if (rx_data !== 8'h5B) begin fails++; $display("FAIL read_ack_data: got %h, required 5b", rx_data); end
    if (rise_sh[0] !== 1'b0) begin fails++; $display("FAIL read_ack_bit9: got %b, required 0", rise_sh[0]); end
    if (ack_rx !== 1'b0) begin fails++; $display("FAIL read_ack_rx_held: got %b, required 0", ack_rx); end
    rd_en = 0;
  endtask
  task automatic test_stretch;
    int n;
    ack_en = 1;
    str_en = 1;
    in_byte = 1;
    issue(CMD_WRITE, 8'h5A, 1'b0);
    wait_done(n);
    in_byte = 0;
    str_en = 0;
    ack_en = 0;
    tests += 4;
    if (n !== 36 * D + 18 + STRETCH) begin fails++; $display("FAIL stretch_cycles: got %0d, required %0d", n, 36 * D + 18 + STRETCH); end
    if (rise_sh[8:0] !== 9'h0B4) begin fails++; $display("FAIL stretch_bits: got %h, required 0b4", rise_sh[8:0]); end
    if (ack_rx !== 1'b1) begin fails++; $display("FAIL stretch_ack: got %b, required 1", ack_rx); end
    if (glitches !== 0) begin fails++; $display("FAIL sda_stable_scl_high: got %0d changes, required 0", glitches); end
  endtask
  task automatic test_reset_mid_byte;
    int n, w;
    rd_en = 1;
    tgt_byte = 8'h0F;
    issue(CMD_READ, 8'h00, 1'b0);
    w = 0;
    while (rel != 4 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    tests++;
    if (rel != 4) begin fails++; $display("FAIL reach_bit4: got bit %0d, required 4", rel); end
    repeat (D) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    rd_en = 0;
    tests += 4;
    if (sda_pd !== 1'b0) begin fails++; $display("FAIL midrst_sda_pd: got %b, required 0", sda_pd); end
    if (scl_pd !== 1'b0) begin fails++; $display("FAIL midrst_scl_pd: got %b, required 0", scl_pd); end
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL midrst_cmd_ready: got %b, required 1", cmd_ready); end
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    issue(CMD_STOP, 8'h00, 1'b0);
    wait_done(n);
    tests += 3;
    if (n !== 4 * D + 2) begin fails++; $display("FAIL stop_cycles: got %0d, required %0d", n, 4 * D + 2); end
    if ({sda_pd, scl_pd} !== 2'b00) begin fails++; $display("FAIL stop_pulldowns: got %b, required 00", {sda_pd, scl_pd}); end
    if ({sda_line, scl_line} !== 2'b11) begin fails++; $display("FAIL stop_lines: got %b, required 11", {sda_line, scl_line}); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_write_ack;
    test_no_responder;
    test_read;
    test_stretch;
    test_reset_mid_byte;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_byte_controller.md
# i2c_byte_controller

Byte-level I2C controller (initiator) engine: the bus-driving counterpart to our I2C target/sniffer logic. It drives the existing open-drain pin primitive through `SDA_PULLDOWN`/`SCL_PULLDOWN` and reads the bus back through `SDA_DIN`/`SCL_DIN`. A host FSM issues START, STOP, WRITE-byte and READ-byte commands over a valid/ready handshake. The engine generates SCL, honours target clock stretching, and reports the received data and ACK status.

## Interface
- `CLK_DIV`, default 30: `ICE_CLK` cycles per SCL quarter-period. 30 gives 100 kHz at 12 MHz. Legal range is 2..65535.
- `ICE_CLK` in 1: system clock.
- `RST` in 1: reset. Synchronous, active-high.
- `CMD_VALID` in 1: command offered.
- `CMD_READY` out 1: engine can accept a command.
- `CMD` in 2: command code. 00 START, 01 STOP, 10 WRITE, 11 READ.
- `TX_DATA` in 8: byte for WRITE. Captured on accept.
- `CMD_NACK` in 1: for READ, 1 sends NACK in the 9th bit and 0 sends ACK. Captured on accept.
- `DONE` out 1: one-cycle pulse when a command completes.
- `RX_DATA` out 8: byte received by the last READ. Held until the next READ completes.
- `ACK_RX` out 1: 1 if the target ACKed the last WRITE (SDA low in the 9th bit). Held until the next WRITE.
- `BUSY` out 1: high from command accept until `DONE`.
- `SDA_DIN`, `SCL_DIN` in 1: raw pad inputs. Unregistered.
- `SDA_PULLDOWN`, `SCL_PULLDOWN` out 1: 1 pulls the line low, 0 releases it.

## Operation
- `SDA_DIN` and `SCL_DIN` each pass through a 2-FF synchroniser. All decisions use the synchronised values `sda_s`/`scl_s`.
- Reset sets: `SDA_PULLDOWN`=0, `SCL_PULLDOWN`=0, `CMD_READY`=1, `BUSY`=0, `DONE`=0, `RX_DATA`=0, `ACK_RX`=0.
- The FSM has states IDLE, START, STOP, BIT, DONE_ST.
  - BIT covers 9 bits: 8 data bits, MSB first, then the ACK bit. A 4-bit bit counter and a 2-bit quarter index track position.
- **Accept:** `CMD_VALID && CMD_READY` in IDLE. Then `CMD_READY`=0 and `BUSY`=1 from the next cycle.
- **START** (4 quarters). Works both from idle and as a repeated start with SCL held low.
  - Q0: release SDA.
  - Q1: release SCL (stretch-wait).
  - Q2: pull SDA low.
  - Q3: pull SCL low.
  - Ends with SCL held low.
- **STOP** (4 quarters).
  - Q0: pull SDA low, SCL low.
  - Q1: release SCL (stretch-wait).
  - Q2: hold.
  - Q3: release SDA.
  - Ends with both lines released.
- **Each bit** (4 quarters).
  - Q0: pull SCL low; set SDA. SDA is pulled low for a 0 and released for a 1. Released when reading.
  - Q1: hold.
  - Q2: release SCL (stretch-wait).
  - Q3: hold SCL high.
  - Sample `sda_s` on the last cycle of Q2.
- **WRITE:**
  - Bits 0-7 drive `TX_DATA[7:0]`, MSB first.
  - Bit 8 releases SDA.
  - `ACK_RX` = !sample.
- **READ:**
  - Bits 0-7 release SDA and shift the samples into `RX_DATA`, MSB first.
  - Bit 8 pulls SDA low iff `CMD_NACK`=0.
- **Hand-back:** after the final Q3, SCL is pulled low (held between commands), except after STOP.
- **Clock stretching:** in any quarter that releases SCL, the quarter counter holds at 0 while `scl_s`=0. Counting starts once `scl_s`=1. There is no timeout.
- The command sequence is the host's responsibility; any code is accepted in any order.
- **Reset mid-command:** both pulldowns are 0 on the next cycle and the FSM returns to IDLE. This can leave the bus mid-transaction; the host recovers by issuing START/STOP.

## Timing
- Quarter length is `CLK_DIV` cycles, plus stretch time, plus the 2-cycle synchroniser lag in released-SCL quarters.
- Unstretched durations:
  - START and STOP: 4·`CLK_DIV` (+2 lag per released quarter).
  - WRITE and READ: 36·`CLK_DIV` (+18 cycles lag).
- `DONE` pulses one cycle after the final quarter ends. In that same cycle:
  - `BUSY` goes to 0 and `CMD_READY` goes to 1.
  - `RX_DATA` and `ACK_RX` are already updated.
- A new command can be accepted in the `DONE` cycle.
- `CMD_VALID` is ignored while `CMD_READY`=0. `TX_DATA`, `CMD` and `CMD_NACK` are sampled only at accept.
- Pin outputs are registered and change on `ICE_CLK` edges only. SDA never changes during a quarter where SCL is released, except the deliberate START/STOP edges.

## Structure
- Package `i2c_pkg`:
  - Command encodings `CMD_START`, `CMD_STOP`, `CMD_WRITE`, `CMD_READ`.
  - The FSM state enum.
  - The quarter-index width.
- Sub-module `i2c_quarter_tick`:
  - Counter of `CLK_DIV` cycles with inputs `hold` (stretch) and `restart`.
  - Emits an `end_of_quarter` pulse.
- The main module holds the FSM, shift register, bit counter, synchronisers and output registers.

## Test plan
- **Reset values:** assert `RST` for 3 cycles with random inputs. Outputs must be pulldowns 0/0, `CMD_READY`=1, `BUSY`=0, `DONE`=0, `RX_DATA`=0x00, `ACK_RX`=0.
- **START + WRITE with ACK:** `CLK_DIV`=4, START then WRITE 0xA5, bus model ACKs. SDA sampled at SCL rising edges must read 1,0,1,0,0,1,0,1. `ACK_RX`=1, and `DONE` pulses exactly 2 times.
- **WRITE with no responder:** WRITE 0x3C, nothing responds. `ACK_RX`=0, and the byte completes in 36·`CLK_DIV`+18 cycles from accept to `DONE`.
- **READ with NACK:** target drives 0x96, READ with `CMD_NACK`=1. `RX_DATA`=0x96, SDA released in the 9th bit. Repeat with `CMD_NACK`=0: SDA low in the 9th bit.
- **Clock stretch:** target holds SCL low 50 cycles in bit 3 of a WRITE. Completion is delayed by exactly 50 cycles, data is unchanged, and SDA is stable while SCL is high.
- **Reset mid-byte:** assert `RST` during bit 4 of a READ. Next cycle, pulldowns are 0/0 and `CMD_READY`=1. STOP then completes normally, with both lines released after `DONE`.
